// File: rtl/bce_pipe.sv
// Two-stage pipelined branch condition evaluator with valid/ready handshakes and flush.
// Optional saturating taken/mispredict counters are built when BCE_PIPE_STATS_EN is defined.
module bce_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       bf,
    input  logic             pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             mispredict,
    output logic             bf_illegal,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       bf_q;
    logic             pred_q;
    logic             taken_q, mispred_q, illegal_q;
    logic             s1_adv, s2_adv, accept;
    logic             cond_taken, cond_illegal, cond_mispred;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && !flush && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_adv) s2_valid_d = s1_valid_q;
            if (s1_adv) s1_valid_d = accept;
        end
    end

    always_comb begin
        cond_taken   = 1'b0;
        cond_illegal = 1'b0;
        case (bf_q)
            4'b0000: cond_taken = a_q[WIDTH-1];
            4'b0001: cond_taken = !a_q[WIDTH-1];
            4'b0010: cond_taken = (a_q == b_q);
            4'b0011: cond_taken = (a_q != b_q);
            4'b0100: cond_taken = a_q[WIDTH-1] || (a_q == '0);
            4'b0101: cond_taken = !a_q[WIDTH-1] && (a_q != '0);
            4'b0110: cond_taken = ($signed(a_q) < $signed(b_q));
            4'b0111: cond_taken = ($signed(a_q) >= $signed(b_q));
            4'b1000: cond_taken = (a_q < b_q);
            4'b1001: cond_taken = (a_q >= b_q);
            4'b1010: cond_taken = 1'b1;
            4'b1011: cond_taken = 1'b0;
            default: cond_illegal = 1'b1;
        endcase
        cond_mispred = !cond_illegal && (cond_taken != pred_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            bf_q       <= '0;
            pred_q     <= 1'b0;
            taken_q    <= 1'b0;
            mispred_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                bf_q   <= bf;
                pred_q <= pred_taken;
            end
            // S2 data only moves when a live S1 entry advances, so a stalled output holds steady
            if (s2_adv && s1_valid_q && !flush) begin
                taken_q   <= cond_taken;
                mispred_q <= cond_mispred;
                illegal_q <= cond_illegal;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign taken      = taken_q;
    assign mispredict = mispred_q;
    assign bf_illegal = illegal_q;

`ifdef BCE_PIPE_STATS_EN
    logic             out_hs;
    logic [CNT_W-1:0] taken_cnt_q, mispred_cnt_q;

    assign out_hs = s2_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q   <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (out_hs && taken_q && (taken_cnt_q != '1))
                taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            if (out_hs && mispred_q && (mispred_cnt_q != '1))
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

    assign taken_cnt   = taken_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`else
    assign taken_cnt   = '0;
    assign mispred_cnt = '0;
`endif

endmodule
